dds_bank_ctrl: RTL and testbench
================================

Name: dds_bank_ctrl

Overview:
Parametrised N-channel DDS core and controller. It generalises the fixed 4-channel DDS output stage and adds these features:
- per-channel phase accumulators with phase offset;
- amplitude scaling and selectable waveform;
- linear frequency ramping;
- double-buffered configuration, committed on dds_sync.
It sits between the frequency source (b_to_f / host config) and the int_dds bus pins.

Parameters:
N_CH, 4, number of DDS channels (1..8)
ACC_W, 32, phase accumulator / tuning word width
DAC_W, 14, DAC sample width (offset binary)
AMP_W, 12, amplitude word width; unity = 2^(AMP_W-1)

Ports:
int_dds_clk_in  in  1  clock
reset  in  1  asynchronous, active-high
cfg_wr  in  1  config write request
cfg_ch  in  3  channel index
cfg_addr  in  3  register: 0 ftw, 1 phase_off, 2 amp, 3 step, 4 ctrl
cfg_data  in  ACC_W  write data
cfg_ready  out  1  write accepted when cfg_wr & cfg_ready
cfg_err  out  1  1-cycle pulse on write to invalid ch/addr
dds_sync  in  1  asynchronous commit strobe
ch_en  in  N_CH  per-channel enable
dac_data  out  N_CH*DAC_W  channel j at [j*DAC_W +: DAC_W]
dds_slp  out  N_CH  DAC sleep
dds_dis  out  N_CH  DAC disable
ramp_busy  out  N_CH  frequency ramp in progress

Behaviour:
- Clocking and reset: reset is asynchronous, active-high; the clock is int_dds_clk_in.
- Reset values:
  - dac_data lanes = 2^(DAC_W-1) (midscale);
  - dds_slp = 0; dds_dis = all 1;
  - ramp_busy = 0; cfg_ready = 1; cfg_err = 0;
  - all shadow, active and accumulator registers = 0.
- Config writes:
  - Accepted writes land in shadow registers only.
  - ctrl bits: [1:0] mode, [2] slp, [3] phase_reset.
  - The upper bits of amp and ctrl are ignored.
  - Write with cfg_ch >= N_CH or cfg_addr > 4: the write is accepted, no register changes, and cfg_err pulses on the next cycle.
- Sync and commit:
  - dds_sync passes through a 2-FF synchroniser and a rising-edge detector.
  - Commit occurs in the cycle after the detected edge, so the commit cycle is 3 clocks after the raw rising edge.
- cfg_ready:
  - cfg_ready = 0 in the commit cycle only.
  - A write held during the commit cycle is accepted on the next cycle and is not part of that commit.
- Commit, per channel:
  - phase_off, amp, mode and slp are copied to active registers; ftw_target = shadow ftw.
  - If step == 0: ftw_cur = ftw_target immediately.
  - If step != 0: ramp_busy = 1.
  - If phase_reset = 1: the accumulator clears to 0 in the same cycle.
- Ramp:
  - Each cycle, ftw_cur moves toward ftw_target by step, clamped so it never overshoots.
  - ramp_busy drops in the cycle ftw_cur == ftw_target.
  - A new commit mid-ramp retargets from the current ftw_cur.
- Accumulator:
  - When ch_en[j] = 1: acc <= acc + ftw_cur each cycle, modulo 2^ACC_W (natural wrap).
  - When ch_en[j] = 0: acc held at 0.
- Sample pipeline:
  - Phase: ph = acc + phase_off (mod 2^ACC_W); p = ph[ACC_W-1 -: DAC_W].
  - Waveform by mode:
    - 0 saw: w = p;
    - 1 triangle: w = {(p[MSB] ? ~p[DAC_W-2:0] : p[DAC_W-2:0]), 1'b0};
    - 2 square: w = p[MSB] ? 2^DAC_W-1 : 0;
    - 3 DC: w = 2^DAC_W-1.
  - Scaling:
    - s = w - 2^(DAC_W-1), signed;
    - amp_eff = min(amp, 2^(AMP_W-1));
    - out = 2^(DAC_W-1) + ((s*amp_eff) >>> (AMP_W-1)), arithmetic shift.
    - The result always fits DAC_W bits, so no saturation is needed.
- Latency: 3 registered stages (phase add, waveform, scale). dac_data reflects an accumulator value 3 cycles later.
- Disabled channel (ch_en[j] = 0):
  - dds_dis[j] = 1 and dac_data lane = midscale, both registered (1-cycle latency).
  - Config and ramp logic still run.
- Sleep: dds_slp[j] = active slp bit, registered.
- Reset mid-ramp or mid-commit: everything returns to the reset values immediately; no partial commit survives.

Test Plan:
- Basic commit:
  - Stimulus: ch0 writes ftw=2^28, amp=2048, mode=0, phase_reset=1; ch_en=1; pulse dds_sync.
  - Response: cfg_ready low exactly one cycle, 3 clocks after the edge. Lane 0 then steps 0,1024,2048,…,15360,0 with period 16.
- Half amplitude:
  - Stimulus: same as basic commit with amp=1024.
  - Response: samples 4096,4608,…,11776.
  - Stimulus: amp=4095.
  - Response: clamps to unity, identical to amp=2048.
- Square and triangle:
  - Stimulus: square, ftw=2^30.
  - Response: 0,0,16383,16383 repeating.
  - Stimulus: triangle, ftw=2^28.
  - Response: 0,2048,…,14336,16382,14334,…
- Ramp:
  - Stimulus: ftw_cur=1000, commit target 1010 with step=4.
  - Response: ftw_cur 1004,1008,1010; ramp_busy high 3 cycles.
  - Stimulus: commit target 990.
  - Response: 1006,…,994,990; ramp_busy deasserts on reaching target.
- Double buffering and contention:
  - Stimulus: write with no sync.
  - Response: output unchanged.
  - Stimulus: write asserted during the commit cycle.
  - Response: accepted one cycle later and not applied until the next sync.
  - Stimulus: write with cfg_ch=6 (N_CH=4).
  - Response: cfg_err pulse, no register change.
- Enable and reset:
  - Stimulus: drop ch_en[1].
  - Response: dis[1]=1 and lane 1 = 8192 next cycle; accumulator restarts from 0 when re-enabled.
  - Stimulus: assert reset mid-ramp.
  - Response: all outputs at reset values asynchronously; ramp_busy=0.

Source files
------------

// File: rtl/dds_bank_ctrl_if.sv
// Host configuration bus for dds_bank_ctrl.
// Signals:
//   cfg_wr    write request, held until accepted (cfg_wr & cfg_ready)
//   cfg_ch    channel index
//   cfg_addr  register: 0 ftw, 1 phase_off, 2 amp, 3 step, 4 ctrl
//   cfg_data  write data
//   cfg_ready slave can accept a write this cycle
//   cfg_err   one-cycle pulse after a write to an invalid channel/register
interface dds_bank_ctrl_if #(
  parameter int unsigned ACC_W = 32
);
  logic             cfg_wr;
  logic [2:0]       cfg_ch;
  logic [2:0]       cfg_addr;
  logic [ACC_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_wr, cfg_ch, cfg_addr, cfg_data, input cfg_ready, cfg_err);
  modport slave  (input cfg_wr, cfg_ch, cfg_addr, cfg_data, output cfg_ready, cfg_err);
endinterface

// File: rtl/dds_bank_ctrl.sv
// N-channel DDS core: per-channel phase accumulator with offset, waveform
// select, amplitude scaling and linear frequency ramping. Host writes land in
// shadow registers and are copied to the active set on a dds_sync rising edge.
// Ports:
//   int_dds_clk_in  clock
//   reset           asynchronous, active-high
//   cfg             configuration bus (slave)
//   dds_sync        asynchronous commit strobe
//   ch_en           per-channel enable
//   dac_data        channel j at [j*DAC_W +: DAC_W], offset binary
//   dds_slp         DAC sleep per channel
//   dds_dis         DAC disable per channel
//   ramp_busy       frequency ramp in progress per channel
module dds_bank_ctrl #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned DAC_W = 14,
  parameter int unsigned AMP_W = 12
) (
  input  logic                  int_dds_clk_in,
  input  logic                  reset,
  dds_bank_ctrl_if.slave        cfg,
  input  logic                  dds_sync,
  input  logic [N_CH-1:0]       ch_en,
  output logic [N_CH*DAC_W-1:0] dac_data,
  output logic [N_CH-1:0]       dds_slp,
  output logic [N_CH-1:0]       dds_dis,
  output logic [N_CH-1:0]       ramp_busy
);
  localparam logic [DAC_W-1:0] MID   = DAC_W'(1 << (DAC_W - 1));
  localparam logic [AMP_W-1:0] UNITY = AMP_W'(1 << (AMP_W - 1));
  localparam int unsigned      PW    = DAC_W + AMP_W + 1;

  logic sync1, sync2, sync3, sync_edge, commit_q, ready_q, err_q;
  logic ch_valid, addr_valid, wr_ok;

  // Synchronise the strobe and detect its rising edge; commit one cycle later.
  always_ff @(posedge int_dds_clk_in or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      commit_q <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      sync1    <= dds_sync;
      sync2    <= sync1;
      sync3    <= sync2;
      commit_q <= sync_edge;
      ready_q  <= ~sync_edge;
      err_q    <= cfg.cfg_wr & ready_q & ~(ch_valid & addr_valid);
    end
  end

  assign sync_edge     = sync2 & ~sync3;
  assign ch_valid      = ({1'b0, cfg.cfg_ch} < 4'(N_CH));
  assign addr_valid    = (cfg.cfg_addr <= 3'd4);
  assign wr_ok         = cfg.cfg_wr & ready_q & ch_valid & addr_valid;
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  for (genvar j = 0; j < N_CH; j++) begin : g_ch
    logic [ACC_W-1:0]       sh_ftw, sh_poff, sh_step;
    logic [AMP_W-1:0]       sh_amp;
    logic [3:0]             sh_ctrl;
    logic [ACC_W-1:0]       poff, ftw_tgt, ftw_cur, step, ftw_nxt, acc;
    logic [AMP_W-1:0]       amp, amp_eff;
    logic [1:0]             mode;
    logic                   slp, busy, sel, slp_q, dis_q;
    logic [DAC_W-1:0]       p_q, w_q, w_c, lane_q;
    logic signed [DAC_W-1:0] s, sc;
    logic signed [PW-1:0]   prod;

    assign sel = wr_ok & (cfg.cfg_ch == 3'(j));

    // Shadow register file.
    always_ff @(posedge int_dds_clk_in or posedge reset) begin
      if (reset) begin
        sh_ftw  <= '0;
        sh_poff <= '0;
        sh_amp  <= '0;
        sh_step <= '0;
        sh_ctrl <= '0;
      end else if (sel) begin
        case (cfg.cfg_addr)
          3'd0:    sh_ftw  <= cfg.cfg_data;
          3'd1:    sh_poff <= cfg.cfg_data;
          3'd2:    sh_amp  <= AMP_W'(cfg.cfg_data);
          3'd3:    sh_step <= cfg.cfg_data;
          3'd4:    sh_ctrl <= 4'(cfg.cfg_data);
          default: ;
        endcase
      end
    end

    // Next ramp value: one step toward the target, clamped at the target.
    always_comb begin
      ftw_nxt = ftw_cur;
      if (ftw_cur < ftw_tgt)
        ftw_nxt = (ftw_tgt - ftw_cur <= step) ? ftw_tgt : ftw_cur + step;
      else if (ftw_cur > ftw_tgt)
        ftw_nxt = (ftw_cur - ftw_tgt <= step) ? ftw_tgt : ftw_cur - step;
    end

    // Active registers and ramp; a commit mid-ramp retargets from ftw_cur.
    always_ff @(posedge int_dds_clk_in or posedge reset) begin
      if (reset) begin
        poff    <= '0;
        amp     <= '0;
        mode    <= '0;
        slp     <= 1'b0;
        ftw_tgt <= '0;
        ftw_cur <= '0;
        step    <= '0;
        busy    <= 1'b0;
      end else if (commit_q) begin
        poff    <= sh_poff;
        amp     <= sh_amp;
        mode    <= sh_ctrl[1:0];
        slp     <= sh_ctrl[2];
        ftw_tgt <= sh_ftw;
        step    <= sh_step;
        if (sh_step == '0) begin
          ftw_cur <= sh_ftw;
          busy    <= 1'b0;
        end else begin
          busy    <= 1'b1;
        end
      end else if (busy) begin
        ftw_cur <= ftw_nxt;
        if (ftw_nxt == ftw_tgt) busy <= 1'b0;
      end
    end

    // Phase accumulator.
    always_ff @(posedge int_dds_clk_in or posedge reset) begin
      if (reset)                       acc <= '0;
      else if (!ch_en[j])              acc <= '0;
      else if (commit_q && sh_ctrl[3]) acc <= '0;
      else                             acc <= acc + ftw_cur;
    end

    // Waveform shaping from the truncated phase.
    always_comb begin
      case (mode)
        2'd0:    w_c = p_q;
        2'd1:    w_c = {(p_q[DAC_W-1] ? ~p_q[DAC_W-2:0] : p_q[DAC_W-2:0]), 1'b0};
        2'd2:    w_c = {DAC_W{p_q[DAC_W-1]}};
        default: w_c = '1;
      endcase
    end

    // Amplitude scaling around midscale; flipping the MSB converts offset binary.
    always_comb begin
      amp_eff = (amp > UNITY) ? UNITY : amp;
      s       = signed'({~w_q[DAC_W-1], w_q[DAC_W-2:0]});
      prod    = PW'(s) * PW'(signed'({1'b0, amp_eff}));
      sc      = DAC_W'(prod >>> (AMP_W - 1));
    end

    // Three-stage sample pipeline plus registered status outputs.
    always_ff @(posedge int_dds_clk_in or posedge reset) begin
      if (reset) begin
        p_q    <= '0;
        w_q    <= '0;
        lane_q <= MID;
        slp_q  <= 1'b0;
        dis_q  <= 1'b1;
      end else begin
        p_q    <= DAC_W'((acc + poff) >> (ACC_W - DAC_W));
        w_q    <= w_c;
        lane_q <= ch_en[j] ? {~sc[DAC_W-1], sc[DAC_W-2:0]} : MID;
        slp_q  <= slp;
        dis_q  <= ~ch_en[j];
      end
    end

    assign dac_data[j*DAC_W +: DAC_W] = lane_q;
    assign dds_slp[j]   = slp_q;
    assign dds_dis[j]   = dis_q;
    assign ramp_busy[j] = busy;
  end
endmodule

// File: tb/tb_dds_bank_ctrl.sv
// Directed self-checking bench for dds_bank_ctrl (N_CH=4, ACC_W=32, DAC_W=14, AMP_W=12).
module tb_dds_bank_ctrl;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned DAC_W = 14;
  localparam int unsigned AMP_W = 12;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  dds_sync;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH*DAC_W-1:0] dac_data;
  logic [N_CH-1:0]       dds_slp, dds_dis, ramp_busy;
  int                    n_cmp = 0;
  int                    n_err = 0;

  dds_bank_ctrl_if #(.ACC_W(ACC_W)) cfg ();

  dds_bank_ctrl #(.N_CH(N_CH), .ACC_W(ACC_W), .DAC_W(DAC_W), .AMP_W(AMP_W)) dut (
    .int_dds_clk_in(clk),
    .reset(reset),
    .cfg(cfg),
    .dds_sync(dds_sync),
    .ch_en(ch_en),
    .dac_data(dac_data),
    .dds_slp(dds_slp),
    .dds_dis(dds_dis),
    .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DAC_W-1:0] lane(input int j);
    return dac_data[j*DAC_W +: DAC_W];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic cfg_write(input logic [2:0] ch, input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    cfg.cfg_wr = 1'b1; cfg.cfg_ch = ch; cfg.cfg_addr = a; cfg.cfg_data = d;
    while (!cfg.cfg_ready && n < 8) begin @(negedge clk); n++; end
    if (n >= 8) begin
      n_cmp++; n_err++;
      $error("FAIL wr_timeout: observed ready=0 expected ready=1");
    end
    @(negedge clk);
    cfg.cfg_wr = 1'b0;
  endtask

  // Pulses dds_sync and checks the cfg_ready dip; returns at the negedge after the commit edge.
  task automatic sync_commit();
    @(negedge clk); dds_sync = 1'b1;
    @(negedge clk); chk("ready_pre1", 64'(cfg.cfg_ready), 64'd1);
    @(negedge clk); dds_sync = 1'b0; chk("ready_pre2", 64'(cfg.cfg_ready), 64'd1);
    @(negedge clk); chk("ready_commit", 64'(cfg.cfg_ready), 64'd0);
    @(negedge clk); chk("ready_post", 64'(cfg.cfg_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; dds_sync = 1'b0; ch_en = '0;
    cfg.cfg_wr = 1'b0; cfg.cfg_ch = '0; cfg.cfg_addr = '0; cfg.cfg_data = '0;
    #3;
    chk("rst_dac", 64'(dac_data), 64'({4{14'd8192}}));
    chk("rst_slp", 64'(dds_slp), 64'd0);
    chk("rst_dis", 64'(dds_dis), 64'hF);
    chk("rst_busy", 64'(ramp_busy), 64'd0);
    chk("rst_ready", 64'(cfg.cfg_ready), 64'd1);
    chk("rst_err", 64'(cfg.cfg_err), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); ch_en = 4'hF;
    @(negedge clk); chk("en_dis", 64'(dds_dis), 64'd0);

    // Basic saw commit, after confirming buffered writes have no effect.
    cfg_write(0, 0, 32'h1000_0000);
    cfg_write(0, 2, 2048);
    cfg_write(0, 4, 4'b1000);
    repeat (4) @(negedge clk);
    chk("nosync_lane0", 64'(lane(0)), 64'd8192);
    sync_commit();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      chk("saw", 64'(lane(0)), 64'((k % 16) * 1024));
      @(negedge clk);
    end

    // Half amplitude.
    cfg_write(0, 2, 1024);
    sync_commit();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk("half_amp", 64'(lane(0)), 64'(4096 + 512 * k));
      @(negedge clk);
    end

    // Amplitude above unity clamps.
    cfg_write(0, 2, 4095);
    sync_commit();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk("amp_clamp", 64'(lane(0)), 64'(1024 * k));
      @(negedge clk);
    end

    // Square.
    cfg_write(0, 0, 32'h4000_0000);
    cfg_write(0, 4, 4'b1010);
    sync_commit();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("square", 64'(lane(0)), ((k % 4) >= 2) ? 64'd16383 : 64'd0);
      @(negedge clk);
    end

    // Triangle.
    cfg_write(0, 0, 32'h1000_0000);
    cfg_write(0, 4, 4'b1001);
    sync_commit();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk("triangle", 64'(lane(0)), (k < 8) ? 64'(2048 * k) : 64'((8191 - 1024 * (k - 8)) * 2));
      @(negedge clk);
    end

    // Ramp up and down on channel 2.
    cfg_write(2, 0, 1000);
    sync_commit();
    chk("ramp_init_cur", 64'(dut.g_ch[2].ftw_cur), 64'd1000);
    chk("ramp_init_busy", 64'(ramp_busy[2]), 64'd0);
    cfg_write(2, 0, 1010);
    cfg_write(2, 3, 4);
    sync_commit();
    chk("up_cur0", 64'(dut.g_ch[2].ftw_cur), 64'd1000);
    chk("up_busy0", 64'(ramp_busy[2]), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("up_cur", 64'(dut.g_ch[2].ftw_cur), (k == 3) ? 64'd1010 : 64'(1000 + 4 * k));
      chk("up_busy", 64'(ramp_busy[2]), (k == 3) ? 64'd0 : 64'd1);
    end
    cfg_write(2, 0, 990);
    sync_commit();
    chk("dn_cur0", 64'(dut.g_ch[2].ftw_cur), 64'd1010);
    chk("dn_busy0", 64'(ramp_busy[2]), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("dn_cur", 64'(dut.g_ch[2].ftw_cur), (k == 5) ? 64'd990 : 64'(1010 - 4 * k));
      chk("dn_busy", 64'(ramp_busy[2]), (k == 5) ? 64'd0 : 64'd1);
    end

    // Write held through the commit cycle is taken one cycle later, outside that commit.
    @(negedge clk); dds_sync = 1'b1;
    @(negedge clk);
    @(negedge clk); dds_sync = 1'b0;
    @(negedge clk);
    chk("cont_ready", 64'(cfg.cfg_ready), 64'd0);
    cfg.cfg_wr = 1'b1; cfg.cfg_ch = 3'd0; cfg.cfg_addr = 3'd2; cfg.cfg_data = 32'd0;
    @(negedge clk);
    chk("cont_not_taken", 64'(dut.g_ch[0].sh_amp), 64'd4095);
    @(negedge clk); cfg.cfg_wr = 1'b0;
    chk("cont_taken", 64'(dut.g_ch[0].sh_amp), 64'd0);
    chk("cont_active", 64'(dut.g_ch[0].amp), 64'd4095);
    @(negedge clk);
    @(negedge clk); chk("cont_tri0", 64'(lane(0)), 64'd0);
    @(negedge clk); chk("cont_tri1", 64'(lane(0)), 64'd2048);
    sync_commit();
    repeat (3) @(negedge clk);
    chk("amp0_a", 64'(lane(0)), 64'd8192);
    @(negedge clk); chk("amp0_b", 64'(lane(0)), 64'd8192);

    // Invalid channel / register.
    chk("err_idle", 64'(cfg.cfg_err), 64'd0);
    cfg_write(6, 0, 123);
    chk("err_ch_pulse", 64'(cfg.cfg_err), 64'd1);
    @(negedge clk); chk("err_ch_clear", 64'(cfg.cfg_err), 64'd0);
    cfg_write(0, 5, 55);
    chk("err_addr_pulse", 64'(cfg.cfg_err), 64'd1);
    chk("err_keep_ftw0", 64'(dut.g_ch[0].sh_ftw), 64'h1000_0000);
    chk("err_keep_ftw2", 64'(dut.g_ch[2].sh_ftw), 64'd990);
    chk("err_keep_poff0", 64'(dut.g_ch[0].sh_poff), 64'd0);
    chk("err_keep_step0", 64'(dut.g_ch[0].sh_step), 64'd0);
    chk("err_keep_ctrl0", 64'(dut.g_ch[0].sh_ctrl), 64'd9);

    // Sleep on ch3, saw on ch1, then disable/re-enable ch1.
    cfg_write(1, 0, 32'h1000_0000);
    cfg_write(1, 2, 2048);
    cfg_write(3, 4, 4'b0100);
    sync_commit();
    chk("slp_lat", 64'(dds_slp), 64'd0);
    @(negedge clk); chk("slp_set", 64'(dds_slp), 64'b1000);
    ch_en = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("dis_flag", 64'(dds_dis), 64'b0010);
      chk("dis_lane1", 64'(lane(1)), 64'd8192);
      chk("dis_acc1", 64'(dut.g_ch[1].acc), 64'd0);
    end
    ch_en = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("reen_lane1", 64'(lane(1)), (k <= 3) ? 64'd0 : 64'(1024 * (k - 3)));
    end
    chk("reen_dis", 64'(dds_dis), 64'd0);

    // Reset in the middle of a ramp.
    cfg_write(2, 0, 2000);
    cfg_write(2, 3, 1);
    sync_commit();
    @(negedge clk); chk("mid_busy", 64'(ramp_busy[2]), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(ramp_busy), 64'd0);
    chk("arst_dac", 64'(dac_data), 64'({4{14'd8192}}));
    chk("arst_dis", 64'(dds_dis), 64'hF);
    chk("arst_slp", 64'(dds_slp), 64'd0);
    chk("arst_ready", 64'(cfg.cfg_ready), 64'd1);
    chk("arst_cur", 64'(dut.g_ch[2].ftw_cur), 64'd0);
    chk("arst_shftw", 64'(dut.g_ch[2].sh_ftw), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 64'(ramp_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
